// File: rtl/video_test_pattern_gen.sv
// Synthetic AXI4-Stream video source: whole frames with SOF on TUSER, EOL on TLAST,
// programmable line/frame blanking and a VSYNC-like level during frame blanking.
module video_test_pattern_gen #(
  parameter int H_ACTIVE         = 1920,
  parameter int V_ACTIVE         = 1080,
  parameter int LINE_GAP_CYCLES  = 16,
  parameter int FRAME_GAP_CYCLES = 1024
) (
  input  logic        axi_aclk,
  input  logic        axi_areset,
  input  logic        ctrl_enable,
  input  logic        ctrl_soft_reset,
  input  logic [1:0]  ctrl_pattern,
  output logic [23:0] m_axis_vid_tdata,
  output logic        m_axis_vid_tvalid,
  input  logic        m_axis_vid_tready,
  output logic        m_axis_vid_tlast,
  output logic        m_axis_vid_tuser,
  output logic        vid_vsync,
  output logic [15:0] sts_frame_cnt,
  output logic        sts_busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FGAP   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;
  localparam logic [1:0] S_LGAP   = 2'd3;

  localparam logic [11:0] X_LAST   = 12'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_ACTIVE - 1);
  localparam logic [11:0] BAR_LAST = 12'((H_ACTIVE / 8) - 1);
  localparam logic [15:0] FG_LAST  = 16'(FRAME_GAP_CYCLES - 1);
  localparam logic [15:0] LG_LAST  = 16'((LINE_GAP_CYCLES > 0) ? LINE_GAP_CYCLES - 1 : 0);
  localparam bit          HAS_LG   = (LINE_GAP_CYCLES > 0);

  logic [1:0]  r_state;
  logic [11:0] r_x;
  logic [10:0] r_y;
  logic [15:0] r_gap;
  logic [1:0]  r_pat;
  logic [2:0]  r_bar;
  logic [11:0] r_bar_cnt;
  logic [23:0] r_idx;
  logic [15:0] r_frame_cnt;
  logic [23:0] r_tdata;
  logic        r_tvalid;
  logic        r_tlast;
  logic        r_tuser;
  logic        r_vsync;
  logic        r_busy;

  logic [1:0]  w_state_n;
  logic [11:0] w_x_n;
  logic [10:0] w_y_n;
  logic [15:0] w_gap_n;
  logic [1:0]  w_pat_n;
  logic [2:0]  w_bar_n;
  logic [11:0] w_bar_cnt_n;
  logic [23:0] w_idx_n;
  logic [15:0] w_frame_cnt_n;
  logic        w_hs;
  logic        w_active_n;

  function automatic logic [23:0] bar_colour(input logic [2:0] bar);
    logic [23:0] c;
    case (bar)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // The pixel index pattern uses the running counter so no multiplier is needed.
  function automatic logic [23:0] pixel(input logic [1:0] pat, input logic [11:0] x,
                                        input logic [10:0] y, input logic [2:0] bar,
                                        input logic [23:0] idx, input logic inv);
    logic [23:0] px;
    case (pat)
      2'd0:    px = bar_colour(bar);
      2'd1:    px = {x[7:0], x[7:0], x[7:0]};
      2'd2:    px = (x[4] ^ y[4] ^ inv) ? 24'hFFFFFF : 24'h000000;
      2'd3:    px = idx;
      default: px = 24'h000000;
    endcase
    return px;
  endfunction

  assign w_hs       = r_tvalid && m_axis_vid_tready;
  assign w_active_n = (w_state_n == S_ACTIVE);

  // Next-state and raster position logic; soft reset overrides all states.
  always_comb begin
    w_state_n     = r_state;
    w_x_n         = r_x;
    w_y_n         = r_y;
    w_gap_n       = r_gap;
    w_pat_n       = r_pat;
    w_bar_n       = r_bar;
    w_bar_cnt_n   = r_bar_cnt;
    w_idx_n       = r_idx;
    w_frame_cnt_n = r_frame_cnt;
    if (ctrl_soft_reset) begin
      w_state_n   = S_IDLE;
      w_x_n       = 12'd0;
      w_y_n       = 11'd0;
      w_gap_n     = 16'd0;
      w_bar_n     = 3'd0;
      w_bar_cnt_n = 12'd0;
      w_idx_n     = 24'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctrl_enable) begin
            w_state_n = S_FGAP;
            w_gap_n   = 16'd0;
          end else begin
            w_state_n = S_IDLE;
          end
        end
        S_FGAP: begin
          if (r_gap == FG_LAST) begin
            w_state_n   = S_ACTIVE;
            w_gap_n     = 16'd0;
            w_pat_n     = ctrl_pattern;
            w_x_n       = 12'd0;
            w_y_n       = 11'd0;
            w_bar_n     = 3'd0;
            w_bar_cnt_n = 12'd0;
            w_idx_n     = 24'd0;
          end else begin
            w_gap_n = r_gap + 16'd1;
          end
        end
        S_ACTIVE: begin
          if (w_hs) begin
            w_idx_n = r_idx + 24'd1;
            if (r_x == X_LAST) begin
              w_x_n       = 12'd0;
              w_bar_n     = 3'd0;
              w_bar_cnt_n = 12'd0;
              w_gap_n     = 16'd0;
              if (r_y == Y_LAST) begin
                w_y_n         = 11'd0;
                w_frame_cnt_n = r_frame_cnt + 16'd1;
                w_state_n     = ctrl_enable ? S_FGAP : S_IDLE;
              end else begin
                w_y_n     = r_y + 11'd1;
                w_state_n = HAS_LG ? S_LGAP : S_ACTIVE;
              end
            end else begin
              w_x_n = r_x + 12'd1;
              // Bar 7 saturates so it absorbs the remainder of H_ACTIVE/8.
              if (r_bar == 3'd7) begin
                w_bar_n = r_bar;
              end else if (r_bar_cnt == BAR_LAST) begin
                w_bar_n     = r_bar + 3'd1;
                w_bar_cnt_n = 12'd0;
              end else begin
                w_bar_cnt_n = r_bar_cnt + 12'd1;
              end
            end
          end else begin
            w_state_n = S_ACTIVE;
          end
        end
        S_LGAP: begin
          if (r_gap == LG_LAST) begin
            w_state_n = S_ACTIVE;
            w_gap_n   = 16'd0;
          end else begin
            w_gap_n = r_gap + 16'd1;
          end
        end
        default: begin
          w_state_n = S_IDLE;
        end
      endcase
    end
  end

  // State registers and outputs, all derived from the next state so they stay aligned.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state     <= S_IDLE;
      r_x         <= 12'd0;
      r_y         <= 11'd0;
      r_gap       <= 16'd0;
      r_pat       <= 2'd0;
      r_bar       <= 3'd0;
      r_bar_cnt   <= 12'd0;
      r_idx       <= 24'd0;
      r_frame_cnt <= 16'd0;
      r_tdata     <= 24'd0;
      r_tvalid    <= 1'b0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_vsync     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_x         <= w_x_n;
      r_y         <= w_y_n;
      r_gap       <= w_gap_n;
      r_pat       <= w_pat_n;
      r_bar       <= w_bar_n;
      r_bar_cnt   <= w_bar_cnt_n;
      r_idx       <= w_idx_n;
      r_frame_cnt <= w_frame_cnt_n;
      r_tvalid    <= w_active_n;
      r_tlast     <= w_active_n && (w_x_n == X_LAST);
      r_tuser     <= w_active_n && (w_x_n == 12'd0) && (w_y_n == 11'd0);
      r_vsync     <= (w_state_n == S_FGAP);
      r_busy      <= (w_state_n != S_IDLE);
      r_tdata     <= w_active_n ? pixel(w_pat_n, w_x_n, w_y_n, w_bar_n, w_idx_n,
                                        w_frame_cnt_n[0]) : 24'd0;
    end
  end

  assign m_axis_vid_tdata  = r_tdata;
  assign m_axis_vid_tvalid = r_tvalid;
  assign m_axis_vid_tlast  = r_tlast;
  assign m_axis_vid_tuser  = r_tuser;
  assign vid_vsync         = r_vsync;
  assign sts_frame_cnt     = r_frame_cnt;
  assign sts_busy          = r_busy;

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// Bench for video_test_pattern_gen: two instances (H=16 and H=20), a frame-level
// reference model, colour-bar vector table and directed enable/soft-reset sequences.
module tb_video_test_pattern_gen;

  localparam int HA = 16;
  localparam int HB = 20;
  localparam int VV = 4;
  localparam int LG = 2;
  localparam int FG = 8;

  logic        clk = 1'b0;
  logic        rst, srst, en_a, en_b, tready;
  logic [1:0]  pat_a, pat_b;
  logic [23:0] da, db;
  logic        va, vb, la, lb, ua, ub, vsa, vsb, bsa, bsb;
  logic [15:0] fca, fcb;

  int n_tests = 0;
  int n_fail  = 0;
  int rmode;          // 0: tready low, 1: random, 2: tready high
  int fa;             // frames completed by instance A, as the model sees it
  logic [25:0] qa[$];
  logic [25:0] qb[$];
  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [25:0] hold_a, hold_b;

  typedef struct {
    bit          use_b;
    int          x;
    int          y;
    logic [23:0] exp;
  } bar_vec_t;
  bar_vec_t bars[14];

  always #5 clk = ~clk;

  video_test_pattern_gen #(.H_ACTIVE(HA), .V_ACTIVE(VV), .LINE_GAP_CYCLES(LG),
                           .FRAME_GAP_CYCLES(FG)) dut_a (
    .axi_aclk(clk), .axi_areset(rst), .ctrl_enable(en_a), .ctrl_soft_reset(srst),
    .ctrl_pattern(pat_a), .m_axis_vid_tdata(da), .m_axis_vid_tvalid(va),
    .m_axis_vid_tready(tready), .m_axis_vid_tlast(la), .m_axis_vid_tuser(ua),
    .vid_vsync(vsa), .sts_frame_cnt(fca), .sts_busy(bsa));

  video_test_pattern_gen #(.H_ACTIVE(HB), .V_ACTIVE(VV), .LINE_GAP_CYCLES(LG),
                           .FRAME_GAP_CYCLES(FG)) dut_b (
    .axi_aclk(clk), .axi_areset(rst), .ctrl_enable(en_b), .ctrl_soft_reset(srst),
    .ctrl_pattern(pat_b), .m_axis_vid_tdata(db), .m_axis_vid_tvalid(vb),
    .m_axis_vid_tready(tready), .m_axis_vid_tlast(lb), .m_axis_vid_tuser(ub),
    .vid_vsync(vsb), .sts_frame_cnt(fcb), .sts_busy(bsb));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int b);
    case (b)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Reference beat {tuser, tlast, tdata} for beat k of a frame, from raster arithmetic.
  function automatic logic [25:0] model_beat(input int pat, input int k, input int fcnt, input int h);
    int x, y, b;
    logic [23:0] d;
    logic [7:0]  xb;
    x = k % h;
    y = k / h;
    case (pat)
      0: begin
        b = x / (h / 8);
        if (b > 7) b = 7;
        d = bar_rgb(b);
      end
      1: begin
        xb = 8'(x);
        d = {xb, xb, xb};
      end
      2: d = ((((x >> 4) ^ (y >> 4) ^ fcnt) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: d = 24'((y * h + x) % 16777216);
    endcase
    return {(k == 0), (x == h - 1), d};
  endfunction

  // One cycle: sample at negedge, check stall stability, pick tready, log handshakes.
  task automatic step();
    logic edge_rst;
    edge_rst = rst || srst;
    @(negedge clk);
    if (stall_a && !edge_rst) check("stall_hold_a", {5'd0, va, ua, la, da}, {5'd0, 1'b1, hold_a});
    if (stall_b && !edge_rst) check("stall_hold_b", {5'd0, vb, ub, lb, db}, {5'd0, 1'b1, hold_b});
    case (rmode)
      0:       tready = 1'b0;
      1:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b1;
    endcase
    if (va && tready) qa.push_back({ua, la, da});
    if (vb && tready) qb.push_back({ub, lb, db});
    stall_a = va && !tready;
    stall_b = vb && !tready;
    hold_a  = {ua, la, da};
    hold_b  = {ub, lb, db};
  endtask

  task automatic wait_beats(input bit use_b, input int n);
    int g = 0;
    while (((use_b ? qb.size() : qa.size()) < n) && g < 3000) begin
      step();
      g++;
    end
    check(use_b ? "beats_reached_b" : "beats_reached_a",
          32'((use_b ? qb.size() : qa.size()) >= n), 32'd1);
  endtask

  task automatic wait_vsync_a();
    int g = 0;
    while (!vsa && g < 300) begin
      step();
      g++;
    end
    check("vsync_seen", {31'd0, vsa}, 32'd1);
  endtask

  task automatic count_vsync_a(output int n);
    n = 0;
    while (vsa && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic check_frame(input bit use_b, input int pat, input int fcnt, input string tag);
    int h, n, sz;
    logic [25:0] got;
    h  = use_b ? HB : HA;
    n  = h * VV;
    sz = use_b ? qb.size() : qa.size();
    check({tag, "_count"}, sz, n);
    for (int k = 0; k < n; k++) begin
      if (k < sz) got = use_b ? qb[k] : qa[k];
      else        got = 26'h3FFFFFF;
      check($sformatf("%s_beat%0d", tag, k), {6'd0, got}, {6'd0, model_beat(pat, k, fcnt, h)});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, g, p;
    bars = '{
      '{0, 0, 0, 24'hFFFFFF}, '{0, 1, 0, 24'hFFFFFF}, '{0, 2, 0, 24'hFFFF00},
      '{0, 3, 1, 24'hFFFF00}, '{0, 4, 0, 24'h00FFFF}, '{0, 10, 2, 24'hFF0000},
      '{0, 14, 0, 24'h000000}, '{0, 15, 3, 24'h000000},
      '{1, 0, 0, 24'hFFFFFF}, '{1, 2, 0, 24'hFFFF00}, '{1, 12, 0, 24'h0000FF},
      '{1, 13, 1, 24'h0000FF}, '{1, 14, 0, 24'h000000}, '{1, 19, 2, 24'h000000}};
    rst = 1'b1; srst = 1'b0; en_a = 1'b0; en_b = 1'b0;
    pat_a = 2'd3; pat_b = 2'd0; tready = 1'b0; rmode = 2; fa = 0;

    repeat (3) step();
    check("reset_outputs", {va, ua, la, vsa, bsa, da}, 32'd0);
    check("reset_frame_cnt", {16'd0, fca}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_disabled", {va, vsa, bsa}, 32'd0);

    // Frame timing with tready held high
    en_a = 1'b1;
    wait_vsync_a();
    check("busy_in_fgap", {31'd0, bsa}, 32'd1);
    count_vsync_a(run);
    check("fgap_len", run, FG);
    check("first_valid", {31'd0, va}, 32'd1);
    for (int l = 0; l < VV; l++) begin
      run = 0; g = 0;
      while (va && g < 100) begin run++; step(); g++; end
      check($sformatf("line%0d_len", l), run, HA);
      if (l < VV - 1) begin
        run = 0; g = 0;
        while (!va && !vsa && g < 100) begin run++; step(); g++; end
        check($sformatf("line%0d_gap", l), run, LG);
      end
    end
    check("vsync_again", {31'd0, vsa}, 32'd1);
    check("frame_cnt_1", {16'd0, fca}, 32'd1);
    check_frame(0, 3, fa, "t1");
    fa++;
    qa.delete();

    // Same frame under random back-pressure
    rmode = 1;
    wait_beats(0, HA * VV);
    step();
    check_frame(0, 3, fa, "t2");
    fa++;
    check("frame_cnt_t2", {16'd0, fca}, fa);
    qa.delete();

    // Random patterns, random back-pressure
    for (int f = 0; f < 4; f++) begin
      p = $urandom_range(0, 3);
      pat_a = 2'(p);
      wait_beats(0, HA * VV);
      step();
      check_frame(0, p, fa, $sformatf("rand%0d_p%0d", f, p));
      fa++;
      check("frame_cnt_rand", {16'd0, fca}, fa);
      qa.delete();
    end

    // Pattern change mid-frame takes effect on the next frame only
    pat_a = 2'd3;
    wait_beats(0, 10);
    pat_a = 2'd1;
    wait_beats(0, HA * VV);
    step();
    check_frame(0, 3, fa, "pchg_cur");
    fa++;
    qa.delete();
    wait_beats(0, HA * VV);
    step();
    check_frame(0, 1, fa, "pchg_next");
    fa++;
    qa.delete();

    // Enable dropped mid-frame: frame completes, then IDLE
    pat_a = 2'd3;
    wait_beats(0, 20);
    en_a = 1'b0;
    wait_beats(0, HA * VV);
    step();
    check_frame(0, 3, fa, "en_drop");
    fa++;
    qa.delete();
    run = 0;
    for (int i = 0; i < 30; i++) begin
      if (va || vsa) run++;
      step();
    end
    check("idle_after_drop", run, 0);
    check("busy_after_drop", {31'd0, bsa}, 32'd0);
    check("frame_cnt_drop", {16'd0, fca}, fa);

    // Soft reset while stalled on beat 20
    en_a = 1'b1;
    rmode = 2;
    wait_beats(0, 20);
    rmode = 0;
    step();
    step();
    check("stalled_beat20", {8'd0, da}, 32'd20);
    srst = 1'b1;
    step();
    check("srst_valid", {31'd0, va}, 32'd0);
    check("srst_busy", {31'd0, bsa}, 32'd0);
    check("srst_frame_cnt", {16'd0, fca}, fa);
    srst = 1'b0;
    qa.delete();
    rmode = 2;
    wait_vsync_a();
    count_vsync_a(run);
    check("srst_fgap_len", run, FG);
    check("srst_first_beat", {7'd0, va, ua, da}, {7'd0, 1'b1, 1'b1, 24'd0});
    wait_beats(0, HA * VV);
    step();
    check_frame(0, 3, fa, "post_srst");
    fa++;
    qa.delete();

    // Colour bars on both widths, one frame each
    pat_a = 2'd0;
    en_a = 1'b0;
    pat_b = 2'd0;
    en_b = 1'b1;
    rmode = 1;
    step();
    en_b = 1'b0;
    wait_beats(0, HA * VV);
    wait_beats(1, HB * VV);
    step();
    for (int i = 0; i < 14; i++) begin
      int k, sz;
      logic [25:0] w;
      k  = bars[i].y * (bars[i].use_b ? HB : HA) + bars[i].x;
      sz = bars[i].use_b ? qb.size() : qa.size();
      if (k < sz) w = bars[i].use_b ? qb[k] : qa[k];
      else        w = 26'h3FFFFFF;
      check($sformatf("bar_vec%0d", i), {8'd0, w[23:0]}, {8'd0, bars[i].exp});
    end
    check_frame(0, 0, fa, "bars_a");
    check_frame(1, 0, 0, "bars_b");
    check("bars_b_frame_cnt", {16'd0, fcb}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
